miriscv_alu_issue: RTL and testbench
====================================

Name: miriscv_alu_issue

Overview:
Decode-and-issue stage that feeds the miriscv ALU. It accepts one 32-bit RV32I instruction per handshake, together with register-file read data and the PC. It decodes the instruction into the ALU operator code and the two operands, then holds them in a registered valid/ready output stage until the ALU side accepts them. It also produces the destination/writeback controls, a branch flag, an illegal-instruction flag, and a count of issued operations.

Parameters:
- CNT_W, default 32: width of the issued-operation counter; the counter wraps.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- instr_valid_i  in  1  upstream instruction valid.
- instr_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  RV32I instruction word.
- pc_i  in  32  PC of instr_i.
- rs1_data_i  in  32  register-file data for instr_i[19:15].
- rs2_data_i  in  32  register-file data for instr_i[24:20].
- alu_valid_o  out  1  issued operation valid.
- alu_ready_i  in  1  ALU side accepts the operation.
- alu_operator_o  out  4  ALU operator, encoded with the shared ALU_* macros.
- alu_operand_a_o  out  32  first operand.
- alu_operand_b_o  out  32  second operand.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  writeback enable.
- branch_o  out  1  operation is a conditional-branch compare.
- illegal_o  out  1  instruction not supported.
- issue_cnt_o  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset values: alu_valid_o, rd_we_o, branch_o and illegal_o are 0. Operator is ALU_ADD. Operands, rd_addr_o and issue_cnt_o are 0.
- Reset asserted mid-operation drops any held operation immediately; it is never issued.
- instr_ready_o = !alu_valid_o || alu_ready_i. This is combinational; there is no bubble at full throughput.
- Input handshake (valid && ready) loads the decoded fields into the output register on that edge. alu_valid_o goes to 1 the next cycle, so latency is 1 cycle.
- Output handshake with no new input clears alu_valid_o.
- Simultaneous output and input handshakes replace the register contents; alu_valid_o stays 1.
- While alu_valid_o=1 and alu_ready_i=0, all outputs hold stable.
- issue_cnt_o increments by 1 on each output handshake and wraps from all-ones to 0.
- OP (0110011): operands are a=rs1, b=rs2.
  - funct7=0x00 maps funct3 000..111 to ADD, SLL, LTS, LTU, XOR, SRL, OR, AND.
  - funct7=0x20 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - For shifts, b = {27'b0, rs2[4:0]}.
- OP-IMM (0010011): a=rs1, b=sign-extended imm[11:0]; mapping as OP without SUB.
  - Shifts use b = {27'b0, instr[24:20]}.
  - Funct3 101 with instr[30]=1 gives SRA.
  - Shifts with instr[31:25] not 0x00/0x20 are illegal.
- BRANCH (1100011): a=rs1, b=rs2, branch_o=1, rd_we_o=0.
  - Funct3 000/001/100/101/110/111 maps to EQ, NE, LTS, GES, LTU, GEU.
  - Funct3 010/011 are illegal.
- LUI (0110111): operator ADD, a=0, b={instr[31:12],12'b0}.
- AUIPC (0010111): operator ADD, a=pc_i, b=U-immediate.
- rd_we_o=1 for OP, OP-IMM, LUI and AUIPC, except rd_we_o=0 when rd=0.
- rd_addr_o=instr[11:7] in all cases, including branches.
- Any other opcode or invalid funct7: illegal_o=1, operator ADD, operands 0, rd_we_o=0, branch_o=0. The instruction is still issued and counted.

Test Plan:
- Reset check: rst_ni=0 asynchronously, with no clock edge required -> all outputs at their reset values; instr_ready_o=1.
- add x3,x1,x2: instr 0x002081B3, rs1=7, rs2=5 -> next cycle valid=1, operator ADD, a=7, b=5, rd=3, we=1.
- sub x3,x1,x2: instr 0x402081B3 -> operator SUB.
- srai x5,x6,3: instr 0x40335293 -> operator SRA, b=3.
- beq x1,x2,8: instr 0x00208463 -> operator EQ, branch_o=1, we=0.
- lui x7,0x12345: instr 0x123453B7 -> operator ADD, a=0, b=0x12345000.
- Backpressure: hold alu_ready_i=0 for 3 cycles after issue -> instr_ready_o=0 and outputs stable. Then set ready=1 with a new valid instruction -> back-to-back replace, issue_cnt_o +1 per cycle.
- Illegal input: instr 0xFFFFFFFF -> illegal_o=1, we=0, operands 0.
- Counter wrap: CNT_W=2, 5 issues -> issue_cnt_o=1.
- Reset mid-hold: rst_ni=0 while alu_valid_o=1 -> alu_valid_o=0 and issue_cnt_o=0 immediately.

Source files
------------

// File: rtl/miriscv_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_alu_issue
// Brief    : RV32I decode-and-issue stage in front of the miriscv ALU. Decodes
//            one instruction per handshake into ALU operator/operands plus
//            writeback, branch and illegal flags, and holds the result in a
//            registered valid/ready output stage. Counts output handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_alu_issue #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    output logic [3:0]       alu_operator_o,
    output logic [31:0]      alu_operand_a_o,
    output logic [31:0]      alu_operand_b_o,
    output logic [4:0]       rd_addr_o,
    output logic             rd_we_o,
    output logic             branch_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] issue_cnt_o
);

    // Shared ALU operator encoding
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_LTS = 4'd3;
    localparam logic [3:0] ALU_LTU = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8;
    localparam logic [3:0] ALU_AND = 4'd9;
    localparam logic [3:0] ALU_EQ  = 4'd10;
    localparam logic [3:0] ALU_NE  = 4'd11;
    localparam logic [3:0] ALU_GES = 4'd12;
    localparam logic [3:0] ALU_GEU = 4'd13;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 -> operator for the plain (funct7 = 0) register/immediate ops
    function automatic logic [3:0] f_base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f_base_op = ALU_ADD;
            3'b001:  f_base_op = ALU_SLL;
            3'b010:  f_base_op = ALU_LTS;
            3'b011:  f_base_op = ALU_LTU;
            3'b100:  f_base_op = ALU_XOR;
            3'b101:  f_base_op = ALU_SRL;
            3'b110:  f_base_op = ALU_OR;
            default: f_base_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_rd_nz;
    logic             w_is_shift;
    logic [31:0]      w_imm_i;
    logic [31:0]      w_imm_u;

    logic [3:0]       w_op;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic             w_we;
    logic             w_br;
    logic             w_ill;

    logic             w_in_hs;
    logic             w_out_hs;

    logic             r_valid;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [4:0]       r_rd;
    logic             r_we;
    logic             r_br;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;

    assign w_opcode   = instr_i[6:0];
    assign w_funct3   = instr_i[14:12];
    assign w_funct7   = instr_i[31:25];
    assign w_rd_nz    = |instr_i[11:7];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_u    = {instr_i[31:12], 12'b0};

    // Output stage can take a new instruction when empty or draining this cycle
    assign instr_ready_o = !r_valid || alu_ready_i;
    assign w_in_hs       = instr_valid_i && instr_ready_o;
    assign w_out_hs      = r_valid && alu_ready_i;

    // Decode: assume illegal, let each recognised encoding clear the flag,
    // then force the canonical illegal payload at the end
    always_comb begin
        w_op  = ALU_ADD;
        w_a   = 32'd0;
        w_b   = 32'd0;
        w_we  = 1'b0;
        w_br  = 1'b0;
        w_ill = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                w_a  = rs1_data_i;
                w_b  = w_is_shift ? {27'b0, rs2_data_i[4:0]} : rs2_data_i;
                w_we = w_rd_nz;
                if (w_funct7 == 7'h00) begin
                    w_ill = 1'b0;
                    w_op  = f_base_op(w_funct3);
                end else if (w_funct7 == 7'h20) begin
                    if (w_funct3 == 3'b000) begin
                        w_ill = 1'b0;
                        w_op  = ALU_SUB;
                    end else if (w_funct3 == 3'b101) begin
                        w_ill = 1'b0;
                        w_op  = ALU_SRA;
                    end
                end
            end
            OPC_OP_IMM: begin
                w_a  = rs1_data_i;
                w_b  = w_is_shift ? {27'b0, instr_i[24:20]} : w_imm_i;
                w_we = w_rd_nz;
                // Only shifts carry a funct7; elsewhere those bits are immediate
                if (!w_is_shift || (w_funct7 == 7'h00) || (w_funct7 == 7'h20)) begin
                    w_ill = 1'b0;
                end
                if ((w_funct3 == 3'b101) && instr_i[30]) begin
                    w_op = ALU_SRA;
                end else begin
                    w_op = f_base_op(w_funct3);
                end
            end
            OPC_BRANCH: begin
                w_a   = rs1_data_i;
                w_b   = rs2_data_i;
                w_br  = 1'b1;
                w_ill = 1'b0;
                case (w_funct3)
                    3'b000:  w_op = ALU_EQ;
                    3'b001:  w_op = ALU_NE;
                    3'b100:  w_op = ALU_LTS;
                    3'b101:  w_op = ALU_GES;
                    3'b110:  w_op = ALU_LTU;
                    3'b111:  w_op = ALU_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_b   = w_imm_u;
                w_we  = w_rd_nz;
                w_ill = 1'b0;
            end
            OPC_AUIPC: begin
                w_a   = pc_i;
                w_b   = w_imm_u;
                w_we  = w_rd_nz;
                w_ill = 1'b0;
            end
            default: ;
        endcase
        if (w_ill) begin
            w_op = ALU_ADD;
            w_a  = 32'd0;
            w_b  = 32'd0;
            w_we = 1'b0;
            w_br = 1'b0;
        end
    end

    // Output register: load on input handshake, drain on output handshake,
    // count every output handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_op    <= ALU_ADD;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_rd    <= 5'd0;
            r_we    <= 1'b0;
            r_br    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_in_hs) begin
                r_valid <= 1'b1;
                r_op    <= w_op;
                r_a     <= w_a;
                r_b     <= w_b;
                r_rd    <= instr_i[11:7];
                r_we    <= w_we;
                r_br    <= w_br;
                r_ill   <= w_ill;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign alu_valid_o     = r_valid;
    assign alu_operator_o  = r_op;
    assign alu_operand_a_o = r_a;
    assign alu_operand_b_o = r_b;
    assign rd_addr_o       = r_rd;
    assign rd_we_o         = r_we;
    assign branch_o        = r_br;
    assign illegal_o       = r_ill;
    assign issue_cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_miriscv_alu_issue
// Brief    : Self-checking bench for miriscv_alu_issue: directed vector table,
//            backpressure / wrap / reset sequences and randomized traffic
//            against a behavioural decode-and-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_alu_issue;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_LTS = 4'd3;
    localparam logic [3:0] ALU_LTU = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8;
    localparam logic [3:0] ALU_AND = 4'd9;
    localparam logic [3:0] ALU_EQ  = 4'd10;
    localparam logic [3:0] ALU_NE  = 4'd11;
    localparam logic [3:0] ALU_GES = 4'd12;
    localparam logic [3:0] ALU_GEU = 4'd13;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        ill;
    } fields_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        fields_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        alu_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;

    logic        instr_ready, alu_valid, we, br, ill;
    logic [3:0]  op;
    logic [31:0] opa, opb, cnt;
    logic [4:0]  rd;

    logic        instr_ready2, alu_valid2, we2, br2, ill2;
    logic [3:0]  op2;
    logic [31:0] opa2, opb2;
    logic [4:0]  rd2;
    logic [1:0]  cnt2;

    miriscv_alu_issue u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
        .alu_operator_o(op), .alu_operand_a_o(opa), .alu_operand_b_o(opb),
        .rd_addr_o(rd), .rd_we_o(we), .branch_o(br), .illegal_o(ill),
        .issue_cnt_o(cnt)
    );

    miriscv_alu_issue #(.CNT_W(2)) u_dut_w2 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready2),
        .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .alu_valid_o(alu_valid2), .alu_ready_i(alu_ready),
        .alu_operator_o(op2), .alu_operand_a_o(opa2), .alu_operand_b_o(opb2),
        .rd_addr_o(rd2), .rd_we_o(we2), .branch_o(br2), .illegal_o(ill2),
        .issue_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;

    // Reference state: one held operation plus a handshake counter
    bit          m_valid = 1'b0;
    fields_t     m_f;
    logic [31:0] m_cnt = 32'd0;
    vec_t        vq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Architectural meaning of each RV32I encoding, from the instruction set rules
    function automatic fields_t ref_decode(input logic [31:0] ins, input logic [31:0] pc_v,
                                           input logic [31:0] a_v, input logic [31:0] b_v);
        fields_t     f;
        logic [3:0]  base_map [8];
        logic [3:0]  br_map [8];
        bit          br_ok [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_u;
        bit          ok, shift;
        base_map = '{ALU_ADD, ALU_SLL, ALU_LTS, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_map   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LTS, ALU_GES, ALU_LTU, ALU_GEU};
        br_ok    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = 32'($signed(ins[31:20]));
        imm_u = ins & 32'hFFFF_F000;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        f     = '0;
        f.op  = ALU_ADD;
        f.rd  = ins[11:7];
        ok    = 1'b0;
        case (ins[6:0])
            7'h33: begin
                f.a  = a_v;
                f.b  = shift ? (b_v % 32) : b_v;
                f.we = (ins[11:7] != 5'd0);
                if (f7 == 7'h00) begin ok = 1'b1; f.op = base_map[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; f.op = ALU_SUB; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; f.op = ALU_SRA; end
            end
            7'h13: begin
                f.a  = a_v;
                f.b  = shift ? 32'(ins[24:20]) : imm_i;
                f.we = (ins[11:7] != 5'd0);
                ok   = !shift || f7 == 7'h00 || f7 == 7'h20;
                f.op = (f3 == 3'd5 && ins[30]) ? ALU_SRA : base_map[f3];
            end
            7'h63: begin
                f.a  = a_v;
                f.b  = b_v;
                f.br = 1'b1;
                ok   = br_ok[f3];
                f.op = br_map[f3];
            end
            7'h37: begin ok = 1'b1; f.b = imm_u; f.we = (ins[11:7] != 5'd0); end
            7'h17: begin ok = 1'b1; f.a = pc_v; f.b = imm_u; f.we = (ins[11:7] != 5'd0); end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            f.op = ALU_ADD; f.a = 32'd0; f.b = 32'd0; f.we = 1'b0; f.br = 1'b0; f.ill = 1'b1;
        end
        return f;
    endfunction

    function automatic fields_t mkf(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] r, input logic w, input logic bb, input logic il);
        fields_t f;
        f.op = o; f.a = a; f.b = b; f.rd = r; f.we = w; f.br = bb; f.ill = il;
        return f;
    endfunction

    task automatic add_vec(input logic [31:0] i_w, input logic [31:0] p, input logic [31:0] x1,
                           input logic [31:0] x2, input fields_t e);
        vec_t v;
        v.instr = i_w; v.pc = p; v.rs1 = x1; v.rs2 = x2; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic compare_outputs(input string tag, input bit force_fields);
        chk({tag, " valid"}, alu_valid, m_valid);
        chk({tag, " valid_w2"}, alu_valid2, m_valid);
        chk({tag, " cnt"}, cnt, m_cnt);
        chk({tag, " cnt_w2"}, cnt2, m_cnt[1:0]);
        if (m_valid || force_fields) begin
            chk({tag, " fields"}, mkf(op, opa, opb, rd, we, br, ill), m_f);
            chk({tag, " fields_w2"}, mkf(op2, opa2, opb2, rd2, we2, br2, ill2), m_f);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i_w, input logic [31:0] p,
                         input logic [31:0] x1, input logic [31:0] x2, input logic ar);
        instr_valid = v; instr = i_w; pc = p; rs1 = x1; rs2 = x2; alu_ready = ar;
    endtask

    // One clock: check combinational ready, advance model and DUT, compare
    task automatic cycle(input string tag);
        bit      in_hs, out_hs;
        fields_t nf;
        #1;
        chk({tag, " ready"}, instr_ready, !m_valid || alu_ready);
        chk({tag, " ready_w2"}, instr_ready2, !m_valid || alu_ready);
        in_hs  = instr_valid && (!m_valid || alu_ready);
        out_hs = m_valid && alu_ready;
        nf     = ref_decode(instr, pc, rs1, rs2);
        @(posedge clk);
        #1;
        if (out_hs) m_cnt = m_cnt + 32'd1;
        if (in_hs) begin m_valid = 1'b1; m_f = nf; end
        else if (out_hs) m_valid = 1'b0;
        compare_outputs(tag, 1'b0);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
        m_f     = mkf(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        compare_outputs(tag, 1'b1);
        chk({tag, " ready"}, instr_ready, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k, s;
        w = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h63;
            5:       w[6:0] = 7'h37;
            6:       w[6:0] = 7'h17;
            default: ;
        endcase
        s = $urandom_range(0, 3);
        if (s == 0 || s == 3) w[31:25] = 7'h00;
        else if (s == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        logic [31:0] snap_cnt;
        fields_t     snap_f;

        #2;
        async_reset("reset");

        add_vec(32'h002081B3, 32'h0,   32'd7,         32'd5,         mkf(ALU_ADD, 32'd7, 32'd5, 5'd3, 1, 0, 0));
        add_vec(32'h402081B3, 32'h0,   32'd7,         32'd5,         mkf(ALU_SUB, 32'd7, 32'd5, 5'd3, 1, 0, 0));
        add_vec(32'h40335293, 32'h0,   32'h8000_0000, 32'd0,         mkf(ALU_SRA, 32'h8000_0000, 32'd3, 5'd5, 1, 0, 0));
        add_vec(32'h00208463, 32'h40,  32'd3,         32'd3,         mkf(ALU_EQ,  32'd3, 32'd3, 5'd8, 0, 1, 0));
        add_vec(32'h123453B7, 32'h0,   32'hDEADBEEF,  32'd1,         mkf(ALU_ADD, 32'd0, 32'h1234_5000, 5'd7, 1, 0, 0));
        add_vec(32'hFFFFFFFF, 32'h80,  32'h1234,      32'h5678,      mkf(ALU_ADD, 32'd0, 32'd0, 5'd31, 0, 0, 1));
        add_vec(32'h00001097, 32'h100, 32'd0,         32'd0,         mkf(ALU_ADD, 32'h100, 32'h1000, 5'd1, 1, 0, 0));
        add_vec(32'hFFF08013, 32'h0,   32'h55,        32'd0,         mkf(ALU_ADD, 32'h55, 32'hFFFF_FFFF, 5'd0, 0, 0, 0));
        add_vec(32'h00209233, 32'h0,   32'd1,         32'hFFFF_FFE5, mkf(ALU_SLL, 32'd1, 32'd5, 5'd4, 1, 0, 0));
        add_vec(32'h0020A463, 32'h0,   32'd9,         32'd9,         mkf(ALU_ADD, 32'd0, 32'd0, 5'd8, 0, 0, 1));
        add_vec(32'h02109093, 32'h0,   32'd4,         32'd0,         mkf(ALU_ADD, 32'd0, 32'd0, 5'd1, 0, 0, 1));
        add_vec(32'h0020F463, 32'h0,   32'hA,         32'hB,         mkf(ALU_GEU, 32'hA, 32'hB, 5'd8, 0, 1, 0));
        add_vec(32'h0020B533, 32'h0,   32'hFFFF_FFFF, 32'd1,         mkf(ALU_LTU, 32'hFFFF_FFFF, 32'd1, 5'd10, 1, 0, 0));
        add_vec(32'h40209233, 32'h0,   32'd1,         32'd2,         mkf(ALU_ADD, 32'd0, 32'd0, 5'd4, 0, 0, 1));
        add_vec(32'h4020D233, 32'h0,   32'hF000_0000, 32'h21,        mkf(ALU_SRA, 32'hF000_0000, 32'd1, 5'd4, 1, 0, 0));
        add_vec(32'h01F15293, 32'h0,   32'h12,        32'd0,         mkf(ALU_SRL, 32'h12, 32'h1F, 5'd5, 1, 0, 0));

        // Directed table, issued back-to-back at full throughput
        foreach (vq[i]) begin
            drive(1'b1, vq[i].instr, vq[i].pc, vq[i].rs1, vq[i].rs2, 1'b1);
            cycle("vec");
            chk($sformatf("vec%0d table", i), mkf(op, opa, opb, rd, we, br, ill), vq[i].exp);
        end

        // Backpressure: drain, issue, stall three cycles, then replace back-to-back
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        cycle("drain");
        drive(1'b1, 32'h002081B3, 32'd0, 32'd7, 32'd5, 1'b0);
        cycle("bp_issue");
        snap_f = mkf(op, opa, opb, rd, we, br, ill);
        snap_cnt = m_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h402081B3, 32'd0, 32'd9, 32'd4, 1'b0);
            cycle("bp_stall");
            chk("bp_stable", mkf(op, opa, opb, rd, we, br, ill), snap_f);
        end
        chk("bp_ready_low", instr_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h402081B3, 32'd0, 32'd20 + 32'(k), 32'd4, 1'b1);
            cycle("bp_replace");
        end
        chk("bp_cnt_plus3", cnt, snap_cnt + 32'd3);

        // Counter wrap: five issues from reset leave the 2-bit counter at 1
        async_reset("wrap_reset");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h00500093 + (32'(k) << 20), 32'd0, 32'd0, 32'd0, 1'b1);
            cycle("wrap");
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        cycle("wrap_drain");
        chk("wrap_cnt2", cnt2, 2'd1);
        chk("wrap_cnt32", cnt, 32'd5);

        // Randomized traffic with random stalls on both sides
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0));
            cycle("rand");
        end

        // Reset while an operation is held: it must vanish and never issue
        drive(1'b1, 32'h002081B3, 32'd0, 32'd1, 32'd2, 1'b0);
        cycle("hold_issue");
        cycle("hold");
        async_reset("mid_reset");
        chk("mid_reset_valid", alu_valid, 1'b0);
        chk("mid_reset_cnt", cnt, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        cycle("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
